// File: rtl/fetch_queue_ctrl_if.sv
// Memory read port of the fetch sequencer: in-order 64-bit read requests and responses.
// Latency: none, plain wires; the controller's combinational request/response logic sits behind them.
// Backpressure: req_valid/req_ready handshake on requests; responses are always accepted.
// Ports (signals): req_valid, req_ready, req_addr (8-byte aligned), resp_valid, resp_data.
// resp_data bit IN_WIDTH-1 is stream index 0, the MSB of the lowest-addressed byte.
interface fetch_queue_ctrl_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int IN_WIDTH   = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid;
  logic [IN_WIDTH-1:0]   resp_data;

  // master: the fetch controller issuing reads; slave: the memory side.
  modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
  modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/fetch_queue_ctrl.sv
// Sequences instruction fetch reads into the bit-granular fetch queue and guards the decoder's dequeue path.
// Latency: request issue and enqueue of a response are combinational in the cycle they occur; redirect flushes next cycle.
// Backpressure: requests held back by free queue space and MAX_OUTSTANDING; req_valid waits on req_ready; responses never stall.
// Ports: clk/reset (sync, active-high); redirect_valid/redirect_addr; mem (fetch_queue_ctrl_if.master);
//        q_flush, q_en_queue, q_in_cnt, q_in_data, q_de_queue, q_out_cnt, q_out_data, q_used_cnt, q_empty_cnt (queue side);
//        dec_data, dec_avail, dec_consume, dec_consume_bits (decoder side).
// Optional: define FETCH_QUEUE_CTRL_PERF_EN to add saturating perf_stall_space / perf_dropped counters.
// Bit ordering: bit W-1 of every data bus is stream index 0 (MSB of the lowest-addressed byte).
module fetch_queue_ctrl #(
  parameter int IN_WIDTH        = 64,
  parameter int OUT_WIDTH       = 64,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  fetch_queue_ctrl_if.master    mem,
  output logic                  q_flush,
  output logic                  q_en_queue,
  output logic [31:0]           q_in_cnt,
  output logic [IN_WIDTH-1:0]   q_in_data,
  output logic                  q_de_queue,
  output logic [31:0]           q_out_cnt,
  input  logic [OUT_WIDTH-1:0]  q_out_data,
  input  logic [31:0]           q_used_cnt,
  input  logic [31:0]           q_empty_cnt,
  output logic [OUT_WIDTH-1:0]  dec_data,
  output logic [31:0]           dec_avail,
  input  logic                  dec_consume,
  input  logic [31:0]           dec_consume_bits
`ifdef FETCH_QUEUE_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_stall_space,
  output logic [31:0]           perf_dropped
`endif
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [2:0]            offset;
  logic                  first_word;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;

  logic                  in_run;
  logic [CW-1:0]         live;
  logic [31:0]           space_need;
  logic                  space_ok;
  logic                  under_limit;
  logic                  req_hs;
  logic [CW-1:0]         out_next;
  logic [5:0]            shamt;
  logic                  over_consume;

  always_comb begin
    in_run      = (state == RUN);
    // Stale requests still in flight will be discarded, so they do not reserve queue space.
    live        = outstanding - drop_cnt;
    space_need  = (32'(live) + 32'd1) * 32'(IN_WIDTH);
    space_ok    = (q_empty_cnt >= space_need);
    under_limit = (32'(outstanding) < 32'(MAX_OUTSTANDING));

    mem.req_valid = in_run && under_limit && space_ok;
    mem.req_addr  = fetch_addr;
    req_hs        = mem.req_valid && mem.req_ready;
    out_next      = outstanding + CW'(req_hs) - CW'(mem.resp_valid);

    q_flush    = (state == FLUSH);
    q_en_queue = mem.resp_valid && (drop_cnt == '0) && in_run && !redirect_valid;

    // First word of a stream skips the bytes below the redirect target.
    shamt     = {offset, 3'b000};
    q_in_cnt  = '0;
    q_in_data = '0;
    if (q_en_queue) begin
      if (first_word) begin
        q_in_cnt  = 32'(IN_WIDTH) - 32'(shamt);
        q_in_data = mem.resp_data << shamt;
      end else begin
        q_in_cnt  = 32'(IN_WIDTH);
        q_in_data = mem.resp_data;
      end
    end

    dec_data  = q_out_data;
    dec_avail = '0;
    if (in_run)
      dec_avail = (q_used_cnt < 32'(OUT_WIDTH)) ? q_used_cnt : 32'(OUT_WIDTH);

    over_consume = dec_consume && in_run && !redirect_valid && (dec_consume_bits > dec_avail);
    q_de_queue   = dec_consume && in_run && !redirect_valid && (dec_consume_bits <= dec_avail);
    q_out_cnt    = q_de_queue ? dec_consume_bits : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fetch_addr  <= '0;
      offset      <= '0;
      first_word  <= 1'b0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        // Everything in flight after this cycle belongs to the old stream.
        state      <= FLUSH;
        fetch_addr <= {redirect_addr[ADDR_WIDTH-1:3], 3'b000};
        offset     <= redirect_addr[2:0];
        first_word <= 1'b1;
        drop_cnt   <= out_next;
      end else begin
        case (state)
          IDLE:    state <= IDLE;
          FLUSH:   state <= RUN;
          default: state <= RUN;
        endcase
        if (req_hs)
          fetch_addr <= fetch_addr + ADDR_WIDTH'(8);
        if (mem.resp_valid && (drop_cnt != '0))
          drop_cnt <= drop_cnt - CW'(1);
        if (q_en_queue)
          first_word <= 1'b0;
      end
    end
  end

`ifdef FETCH_QUEUE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_space <= '0;
      perf_dropped     <= '0;
    end else begin
      if (in_run && under_limit && !space_ok && (perf_stall_space != '1))
        perf_stall_space <= perf_stall_space + 32'd1;
      // Any response not enqueued is discarded: stale, during FLUSH, or in a redirect cycle.
      if (mem.resp_valid && !q_en_queue && (perf_dropped != '1))
        perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(mem.resp_valid && (outstanding == '0)))
        else $fatal(1, "fetch_queue_ctrl: response with no outstanding request");
      assert (!(q_en_queue && (q_empty_cnt < 32'(IN_WIDTH))))
        else $fatal(1, "fetch_queue_ctrl: enqueue into a queue without room for a word");
      assert (!over_consume)
        else $warning("fetch_queue_ctrl: decoder consume exceeds available bits, ignored");
    end
  end

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
module tb_fetch_queue_ctrl;
  localparam int QCAP = 256;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_addr;
  logic        q_flush, q_en_queue, q_de_queue;
  logic [31:0] q_in_cnt, q_out_cnt;
  logic [63:0] q_in_data, q_out_data, dec_data;
  logic [31:0] q_used_cnt, q_empty_cnt, dec_avail;
  logic        dec_consume;
  logic [31:0] dec_consume_bits;

  fetch_queue_ctrl_if #(.ADDR_WIDTH(64), .IN_WIDTH(64)) mem_if ();

  fetch_queue_ctrl dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .mem(mem_if),
    .q_flush(q_flush), .q_en_queue(q_en_queue), .q_in_cnt(q_in_cnt), .q_in_data(q_in_data),
    .q_de_queue(q_de_queue), .q_out_cnt(q_out_cnt), .q_out_data(q_out_data),
    .q_used_cnt(q_used_cnt), .q_empty_cnt(q_empty_cnt),
    .dec_data(dec_data), .dec_avail(dec_avail),
    .dec_consume(dec_consume), .dec_consume_bits(dec_consume_bits)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          q_used = 0;
  logic [63:0] mq[$];
  logic        mem_en;

  function automatic logic [63:0] mdata(input logic [63:0] a);
    return {a[31:0] ^ 32'hDEAD_BEEF, a[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample DUT outputs, advance the queue and memory models, drive next inputs.
  task automatic cycle();
    logic        hs, en, de, fl;
    logic [63:0] a;
    logic [31:0] ic, oc;
    #1;
    hs = mem_if.req_valid && mem_if.req_ready;
    a  = mem_if.req_addr;
    en = q_en_queue; ic = q_in_cnt;
    de = q_de_queue; oc = q_out_cnt;
    fl = q_flush;
    @(posedge clk);
    #1;
    if (fl) q_used = 0;
    else    q_used = q_used + (en ? int'(ic) : 0) - (de ? int'(oc) : 0);
    if (hs) mq.push_back(a);
    if (mem_en && mq.size() > 0) begin
      mem_if.resp_valid = 1'b1;
      mem_if.resp_data  = mdata(mq.pop_front());
    end else begin
      mem_if.resp_valid = 1'b0;
      mem_if.resp_data  = '0;
    end
    q_used_cnt  = 32'(q_used);
    q_empty_cnt = 32'(QCAP - q_used);
    #1;
  endtask

  // Drain, redirect to addr, then leave nreq requests held unanswered at the memory.
  task automatic start_stream(input logic [63:0] addr, input int nreq);
    mem_if.req_ready = 1'b0;
    mem_en = 1'b1;
    repeat (6) cycle();
    redirect_valid = 1'b1;
    redirect_addr  = addr;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    mem_en = 1'b0;
    mem_if.req_ready = 1'b1;
    for (int i = 0; i < 10 && mq.size() < nreq; i++) cycle();
    mem_if.req_ready = 1'b0;
    check("stream_held", 64'(mq.size()), 64'(nreq));
  endtask

  // Expect n discarded responses, then the first word of the new stream at addr.
  task automatic check_drop(input int n, input logic [63:0] addr);
    int seen;
    bit done;
    seen = 0;
    done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (mem_if.resp_valid) begin
        if (seen < n) begin
          check("stale_no_enq", 64'(q_en_queue), 64'd0);
          seen++;
        end else begin
          check("fresh_enq", 64'(q_en_queue), 64'd1);
          check("fresh_cnt", 64'(q_in_cnt), 64'd64);
          check("fresh_data", q_in_data, mdata(addr));
          done = 1'b1;
        end
      end
      if (done) break;
      cycle();
    end
    check("drop_done", 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] next_req, next_resp, exp_d;
    int          n_hs;
    logic        hs;

    reset = 1'b1; redirect_valid = 1'b0; redirect_addr = '0;
    mem_if.req_ready = 1'b1; mem_if.resp_valid = 1'b0; mem_if.resp_data = '0;
    q_out_data = 64'h0123_4567_89AB_CDEF;
    q_used_cnt = 32'd0; q_empty_cnt = 32'(QCAP);
    dec_consume = 1'b0; dec_consume_bits = '0;
    mem_en = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    #1;
    check("rst_req_valid", 64'(mem_if.req_valid), 64'd0);
    check("rst_q_flush", 64'(q_flush), 64'd0);
    check("rst_q_en_queue", 64'(q_en_queue), 64'd0);
    check("rst_q_de_queue", 64'(q_de_queue), 64'd0);
    check("rst_q_in_cnt", 64'(q_in_cnt), 64'd0);
    check("rst_q_out_cnt", 64'(q_out_cnt), 64'd0);
    check("rst_dec_avail", 64'(dec_avail), 64'd0);
    cycle();
    check("idle_no_req", 64'(mem_if.req_valid), 64'd0);

    // Aligned stream at 0x1000, memory always ready with one cycle of latency.
    redirect_valid = 1'b1; redirect_addr = 64'h1000;
    cycle();
    redirect_valid = 1'b0;
    check("t1_flush", 64'(q_flush), 64'd1);
    check("t1_flush_no_req", 64'(mem_if.req_valid), 64'd0);
    cycle();
    check("t1_run_req", 64'(mem_if.req_valid), 64'd1);
    next_req = 64'h1000; next_resp = 64'h1000; n_hs = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_if.req_valid) check("t1_req_addr", mem_if.req_addr, next_req);
      if (q_en_queue) begin
        check("t1_in_cnt", 64'(q_in_cnt), 64'd64);
        check("t1_in_data", q_in_data, mdata(next_resp));
        next_resp = next_resp + 64'd8;
      end
      hs = mem_if.req_valid && mem_if.req_ready;
      cycle();
      if (hs) begin next_req = next_req + 64'd8; n_hs++; end
    end
    check("t1_req_total", 64'(n_hs), 64'd4);
    check("t1_used_full", 64'(q_used), 64'd256);
    check("t1_no_more_req", 64'(mem_if.req_valid), 64'd0);
    check("t1_dec_avail_min", 64'(dec_avail), 64'd64);
    check("t1_dec_data", dec_data, 64'h0123_4567_89AB_CDEF);

    // Unaligned redirect: first word trimmed by three bytes.
    redirect_valid = 1'b1; redirect_addr = 64'h1003;
    cycle();
    redirect_valid = 1'b0;
    check("t2_flush", 64'(q_flush), 64'd1);
    cycle();
    check("t2_req_valid", 64'(mem_if.req_valid), 64'd1);
    check("t2_req_addr", mem_if.req_addr, 64'h1000);
    cycle();
    exp_d = mdata(64'h1000);
    exp_d = exp_d << 24;
    check("t2_first_en", 64'(q_en_queue), 64'd1);
    check("t2_first_cnt", 64'(q_in_cnt), 64'd40);
    check("t2_first_data", q_in_data, exp_d);
    cycle();
    check("t2_second_en", 64'(q_en_queue), 64'd1);
    check("t2_second_cnt", 64'(q_in_cnt), 64'd64);
    check("t2_second_data", q_in_data, mdata(64'h1008));

    // Three requests in flight, then redirect: their responses are discarded.
    start_stream(64'h8000, 3);
    redirect_valid = 1'b1; redirect_addr = 64'h2000;
    cycle();
    redirect_valid = 1'b0; mem_if.req_ready = 1'b1; mem_en = 1'b1;
    check("t3_flush", 64'(q_flush), 64'd1);
    check_drop(3, 64'h2000);

    // Redirect coinciding with a response and a request handshake, two outstanding.
    start_stream(64'h5000, 2);
    mem_en = 1'b1;
    cycle();
    mem_if.req_ready = 1'b1;
    redirect_valid = 1'b1; redirect_addr = 64'h6000;
    dec_consume = 1'b1; dec_consume_bits = 32'd1;
    #1;
    check("t4_req_valid", 64'(mem_if.req_valid), 64'd1);
    check("t4_resp_present", 64'(mem_if.resp_valid), 64'd1);
    check("t4_no_enq", 64'(q_en_queue), 64'd0);
    check("t4_no_deq", 64'(q_de_queue), 64'd0);
    cycle();
    redirect_valid = 1'b0; dec_consume = 1'b0;
    check("t4_flush", 64'(q_flush), 64'd1);
    check_drop(2, 64'h6000);

    // Memory not ready for 10 cycles, then outstanding limit.
    start_stream(64'h7000, 0);
    for (int i = 0; i < 10; i++) begin
      check("t5_hold_valid", 64'(mem_if.req_valid), 64'd1);
      check("t5_hold_addr", mem_if.req_addr, 64'h7000);
      cycle();
    end
    mem_if.req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("t5_max_out", 64'(mq.size() <= 4), 64'd1);
    end
    check("t5_out_reached", 64'(mq.size()), 64'd4);
    check("t5_limit_stop", 64'(mem_if.req_valid), 64'd0);

    // Guarded dequeue with 16 bits in the queue.
    mem_if.req_ready = 1'b0;
    q_used = 16;
    q_used_cnt = 32'd16; q_empty_cnt = 32'(QCAP - 16);
    dec_consume = 1'b1; dec_consume_bits = 32'd24;
    #1;
    check("t6_avail", 64'(dec_avail), 64'd16);
    check("t6_over_no_deq", 64'(q_de_queue), 64'd0);
    check("t6_over_cnt", 64'(q_out_cnt), 64'd0);
    cycle();
    dec_consume_bits = 32'd16;
    #1;
    check("t6_deq", 64'(q_de_queue), 64'd1);
    check("t6_deq_cnt", 64'(q_out_cnt), 64'd16);
    cycle();
    dec_consume = 1'b0;
    check("t6_used_after", 64'(q_used), 64'd0);
    check("t6_avail_after", 64'(dec_avail), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
